pipe_stage_skid: RTL and testbench

- Parametrised successor to the plain pipeline stage register (IF/ID, ID/EX, ...).
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under back-pressure, a synchronous flush that injects a configurable bubble value, and an occupancy output.
- Sits between any two pipeline stages. The producer drives in_*, the consumer drives out_ready.

---
 rtl/pipe_stage_skid_pkg.sv | 24 ++
 rtl/pipe_slot.sv | 43 ++++
 rtl/pipe_stage_skid.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
//   OCC_W     : width of the occupancy output (holds 0..2).
//   PIPE_NOP  : instruction NOP encoding, the usual FLUSH_VALUE for IF/ID.
//   occ_e     : named occupancy states used by the stage control logic.
//   occ_of()  : maps the two slot valid bits onto an occ_e.
package pipe_stage_skid_pkg;

  localparam int          OCC_W    = 2;
  localparam logic [31:0] PIPE_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // The skid slot is only ever filled while main is full, so the sum is 0..2.
  function automatic occ_e occ_of(input logic main_v, input logic skid_v);
    logic [OCC_W-1:0] sum;
    sum = {1'b0, main_v} + {1'b0, skid_v};
    return occ_e'(sum);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-low reset.
//   load     : capture d and mark valid.
//   unload   : mark empty, keep the data (the output holds its last value).
//   clear    : mark empty and force data to CLEAR_VALUE; beats load/unload.
//   d        : data to capture.
//   valid, q : slot contents.
module pipe_slot #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             unload,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      // NOTE: the data register is reset too, because out_data has a defined
      // post-reset value; a plain storage array would not need this.
      q     <= RESET_VALUE;
    end else if (clear) begin
      valid <= 1'b0;
      q     <= CLEAR_VALUE;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid
// buffer. Full throughput under back-pressure; in_ready comes straight from
// a flop so there is no combinational path from out_ready to in_ready.
// Ports:
//   clk, rst            : rising-edge clock, asynchronous active-low reset.
//   in_valid/in_ready   : producer handshake; in_data is its payload.
//   flush               : synchronous clear; out_data becomes FLUSH_VALUE.
//   out_valid/out_ready : consumer handshake; out_data is the head payload.
//   occupancy           : number of entries held (0..2).
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic             main_v, skid_v;
  logic [WIDTH-1:0] main_q, skid_q;
  logic [WIDTH-1:0] main_d;
  logic             accept, pop;
  logic             main_load, main_from_skid, main_unload;
  logic             skid_load, skid_unload;
  occ_e             occ;

  // The skid slot is empty exactly when the stage can take another word, so
  // its valid flop doubles as the registered in_ready.
  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occ       = occ_of(main_v, skid_v);
  assign occupancy = occ;

  assign accept = in_valid & in_ready;
  assign pop    = main_v & out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    main_unload    = 1'b0;
    skid_load      = 1'b0;
    skid_unload    = 1'b0;
    case (occ)
      OCC_EMPTY: main_load = accept;
      OCC_ONE: begin
        if (pop) begin
          main_load   = accept;
          main_unload = ~accept;
        end else begin
          // Consumer stalled: park the new word behind main.
          skid_load = accept;
        end
      end
      OCC_FULL: begin
        // in_ready is low here, so only a pop can move data: skid -> main.
        if (pop) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_unload    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_slot #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE),
    .CLEAR_VALUE(FLUSH_VALUE)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .unload(main_unload),
    .clear (flush),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  // Skid data is never observable while empty, so its clear value is moot.
  pipe_slot #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RESET_VALUE),
    .CLEAR_VALUE(RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .unload(skid_unload),
    .clear (flush),
    .d     (in_data),
    .valid (skid_v),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. A queue-based model (at most two
// entries, FIFO order) predicts every output after every clock edge.
module tb_pipe_stage_skid;

  localparam int          W     = 32;
  localparam logic [W-1:0] FLUSH = 32'h0000_F000;
  localparam logic [W-1:0] RSTV  = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words held, in order, plus the last shown out_data.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_data = RSTV;

  pipe_stage_skid #(
    .WIDTH      (W),
    .FLUSH_VALUE(FLUSH),
    .RESET_VALUE(RSTV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, W'(out_valid), W'(mq.size() > 0));
    check({tag, ".out_data"},  out_data,      m_data);
    check({tag, ".in_ready"},  W'(in_ready),  W'(mq.size() < 2));
    check({tag, ".occupancy"}, W'(occupancy), W'(mq.size()));
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = RSTV;
  endtask

  // One clock edge of the stage, from the handshake rules alone.
  task automatic model_edge();
    bit pop, acc;
    if (flush) begin
      mq.delete();
      m_data = FLUSH;
    end else begin
      pop = (mq.size() > 0) && out_ready;
      acc = in_valid && (mq.size() < 2);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(in_data);
      if (mq.size() > 0) m_data = mq[0];
    end
  endtask

  // Advance one edge, update the model, then check 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    // ---- Reset held for two cycles with in_valid high ----
    rst = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #1;
    check_outputs("reset_init");
    step("reset_hold0");
    step("reset_hold1");
    rst = 1'b1;  // released away from the edge
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    step("first_accept");
    check("first_accept.word", out_data, 32'h1234_5678);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("first_drain");

    // ---- Streaming at one word per cycle ----
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'h1111_0000 + W'(i), 1'b1, 1'b0);
      step("stream");
      check("stream.word", out_data, 32'h1111_0000 + W'(i));
      check("stream.occ_le1", W'(occupancy <= 2'd1), W'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step("stream_drain");

    // ---- Back-pressure fills the skid slot ----
    drive(1'b1, 32'hABAB_0001, 1'b0, 1'b0);
    step("bp_w1");
    drive(1'b1, 32'hABAB_0002, 1'b0, 1'b0);
    step("bp_w2");
    check("bp.occ2", W'(occupancy), W'(2));
    check("bp.head", out_data, 32'hABAB_0001);
    drive(1'b1, 32'hABAB_0003, 1'b0, 1'b0);
    step("bp_w3_refused");
    check("bp.held", out_data, 32'hABAB_0001);
    drive(1'b1, 32'hABAB_0003, 1'b1, 1'b0);
    step("bp_pop1");
    check("bp.order2", out_data, 32'hABAB_0002);
    step("bp_pop2");
    check("bp.order3", out_data, 32'hABAB_0003);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("bp_pop3");

    // ---- Flush with a full skid slot ----
    drive(1'b1, 32'hC0DE_0001, 1'b0, 1'b0);
    step("fl_w1");
    drive(1'b1, 32'hC0DE_0002, 1'b0, 1'b0);
    step("fl_w2");
    drive(1'b1, 32'hC0DE_0099, 1'b1, 1'b1);
    step("flush");
    check("flush.value", out_data, 32'h0000_F000);
    drive(1'b0, '0, 1'b1, 1'b0);
    step("post_flush0");
    step("post_flush1");

    // ---- Asynchronous reset mid-operation ----
    drive(1'b1, 32'h5A5A_0001, 1'b0, 1'b0);
    step("ar_w1");
    drive(1'b1, 32'h5A5A_0002, 1'b0, 1'b0);
    step("ar_w2");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst_now");
    step("async_rst_hold");
    rst = 1'b1;
    drive(1'b0, '0, 1'b1, 1'b0);
    step("ar_release0");
    step("ar_release1");

    // ---- Random traffic against the model ----
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
